// File: rtl/mton_fifo_pkg.sv
// mton_fifo_pkg
//   Shared constants and helpers for mton_rr_async_fifo:
//   - ARB_RR / ARB_FIXED : arbiter mode selectors
//   - STAT_W             : width of the optional statistics counters
//   - src_width()        : bits needed to tag an entry with its writer lane
//   - bin2gray/gray2bin  : 32-bit pointer code conversions (callers cast down)
package mton_fifo_pkg;

   localparam int ARB_RR    = 0;
   localparam int ARB_FIXED = 1;
   localparam int STAT_W    = 32;

   // A single writer still gets one tag bit so the source field never collapses.
   function automatic int src_width(input int m);
      return (m <= 1) ? 1 : $clog2(m);
   endfunction

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b = g;
      for (int i = 1; i < 32; i++) b = b ^ (g >> i);
      return b;
   endfunction

endpackage

// File: rtl/mton_rr_arbiter.sv
// mton_rr_arbiter
//   One-hot request arbiter, combinational grant.
//   MODE = ARB_RR    : search starts at the lane after the last granted lane;
//                      the pointer moves only when 'advance' reports a real grant.
//   MODE = ARB_FIXED : lowest requesting lane index wins.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset (pointer -> lane 0)
//   req       : per-lane request
//   advance   : the grant was actually taken this cycle
//   grant     : one-hot grant (may be gated off by the caller)
module mton_rr_arbiter
   import mton_fifo_pkg::*;
#(
   parameter int REQ_N = 2,
   parameter int MODE  = ARB_RR
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [REQ_N-1:0] req,
   input  logic             advance,
   output logic [REQ_N-1:0] grant
);

   localparam int PTR_W = (REQ_N > 1) ? $clog2(REQ_N) : 1;

   logic [PTR_W-1:0] ptr;
   logic [PTR_W-1:0] win;
   logic             found;
   int               idx;

   always_comb begin
      grant = '0;
      win   = ptr;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < REQ_N; i++) begin
         if (MODE == ARB_FIXED) idx = i;
         else                   idx = (int'(ptr) + i) % REQ_N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win        = PTR_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         ptr <= '0;
      else if (advance && MODE == ARB_RR)
         ptr <= (int'(win) == REQ_N - 1) ? '0 : win + 1'b1;
   end

endmodule

// File: rtl/mton_rr_async_fifo.sv
// mton_rr_async_fifo
//   Dual-clock FIFO shared by M_WRITERS writer lanes and N_READERS reader lanes.
//   Each side arbitrates one transfer per clock, so the Gray pointers crossing
//   domains change by at most one bit per cycle. Entries carry the writer lane ID.
// Ports:
//   write side : i_wr_clk, i_wr_rstn, i_wr_en, i_wr_data, o_wr_ed (grant),
//                o_wr_full/afull/pfull, o_wr_remain
//   read side  : i_rd_clk, i_rd_rstn, i_rd_en, o_rd_data, o_rd_src, o_rd_valid,
//                o_rd_empty/aempty/pempty, o_rd_depth
// Build option:
//   MTON_FIFO_STATS_EN adds saturating trial/count/fail counters per domain.
module mton_rr_async_fifo
   import mton_fifo_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 5,
   parameter int PFULL_TH  = 8,
   parameter int PEMPTY_TH = 8,
   parameter int M_WRITERS = 2,
   parameter int N_READERS = 2,
   parameter int ARB_MODE  = ARB_RR,
   localparam int SRC_W    = src_width(M_WRITERS)
) (
   input  logic                          i_wr_clk,
   input  logic                          i_wr_rstn,
   input  logic                          i_rd_clk,
   input  logic                          i_rd_rstn,
   input  logic [M_WRITERS-1:0]          i_wr_en,
   input  logic [M_WRITERS*WIDTH-1:0]    i_wr_data,
   output logic [M_WRITERS-1:0]          o_wr_ed,
   output logic                          o_wr_full,
   output logic                          o_wr_afull,
   output logic                          o_wr_pfull,
   output logic [DEPTH:0]                o_wr_remain,
   input  logic [N_READERS-1:0]          i_rd_en,
   output logic [N_READERS*WIDTH-1:0]    o_rd_data,
   output logic [N_READERS*SRC_W-1:0]    o_rd_src,
   output logic [N_READERS-1:0]          o_rd_valid,
   output logic                          o_rd_empty,
   output logic                          o_rd_aempty,
   output logic                          o_rd_pempty,
   output logic [DEPTH:0]                o_rd_depth
`ifdef MTON_FIFO_STATS_EN
  ,output logic [STAT_W-1:0]             o_wr_trial,
   output logic [STAT_W-1:0]             o_wr_count,
   output logic [STAT_W-1:0]             o_wr_fail,
   output logic [STAT_W-1:0]             o_rd_trial,
   output logic [STAT_W-1:0]             o_rd_count,
   output logic [STAT_W-1:0]             o_rd_fail
`endif
);

   localparam int PW = DEPTH + 1;
   localparam int EW = WIDTH + SRC_W;
   localparam logic [PW-1:0] CAP    = PW'(2**DEPTH);
   localparam logic [PW-1:0] PFULL  = PW'(PFULL_TH);
   localparam logic [PW-1:0] PEMPTY = PW'(PEMPTY_TH);

   // entry layout: {writer lane, data}; never reset
   logic [EW-1:0] mem [0:(2**DEPTH)-1];

   // ---------------- write domain ----------------
   logic [M_WRITERS-1:0] wr_arb_gnt;
   logic                 push;
   logic [EW-1:0]        wr_entry;
   logic [PW-1:0]        wbin, wgray, wbin_nxt, wgray_nxt;
   logic [PW-1:0]        rq1, rq2, rsync_bin_nxt, remain_nxt;
   logic [PW-1:0]        rgray;

   mton_rr_arbiter #(.REQ_N(M_WRITERS), .MODE(ARB_MODE)) u_wr_arb (
      .clk(i_wr_clk), .rstn(i_wr_rstn), .req(i_wr_en), .advance(push), .grant(wr_arb_gnt)
   );

   assign o_wr_ed = (i_wr_rstn && !o_wr_full) ? wr_arb_gnt : '0;
   assign push    = |o_wr_ed;

   always_comb begin
      wr_entry = '0;
      for (int m = 0; m < M_WRITERS; m++)
         if (o_wr_ed[m]) wr_entry = {SRC_W'(m), i_wr_data[m*WIDTH +: WIDTH]};
   end

   // Flags are computed from the values every pointer takes at this edge
   // (rq1 is what rq2 becomes), so they line up with the registered pointers.
   assign wbin_nxt      = wbin + PW'(push);
   assign wgray_nxt     = PW'(bin2gray(32'(wbin_nxt)));
   assign rsync_bin_nxt = PW'(gray2bin(32'(rq1)));
   assign remain_nxt    = CAP - (wbin_nxt - rsync_bin_nxt);

   always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
      if (!i_wr_rstn) begin
         wbin        <= '0;
         wgray       <= '0;
         rq1         <= '0;
         rq2         <= '0;
         o_wr_full   <= 1'b0;
         o_wr_afull  <= 1'b0;
         o_wr_pfull  <= 1'b0;
         o_wr_remain <= CAP;
      end else begin
         wbin        <= wbin_nxt;
         wgray       <= wgray_nxt;
         rq1         <= rgray;
         rq2         <= rq1;
         o_wr_full   <= (remain_nxt == '0);
         o_wr_afull  <= (remain_nxt <= PW'(1));
         o_wr_pfull  <= (remain_nxt <= PFULL);
         o_wr_remain <= remain_nxt;
      end
   end

   always_ff @(posedge i_wr_clk)
      if (push) mem[wbin[DEPTH-1:0]] <= wr_entry;

   // ---------------- read domain ----------------
   logic [N_READERS-1:0] rd_arb_gnt, serve;
   logic                 pop;
   logic [EW-1:0]        rd_entry;
   logic [PW-1:0]        rbin, rbin_nxt, rgray_nxt;
   logic [PW-1:0]        wq1, wq2, wsync_bin_nxt, depth_nxt;

   mton_rr_arbiter #(.REQ_N(N_READERS), .MODE(ARB_MODE)) u_rd_arb (
      .clk(i_rd_clk), .rstn(i_rd_rstn), .req(i_rd_en), .advance(pop), .grant(rd_arb_gnt)
   );

   assign serve         = (i_rd_rstn && !o_rd_empty) ? rd_arb_gnt : '0;
   assign pop           = |serve;
   assign rd_entry      = mem[rbin[DEPTH-1:0]];
   assign rbin_nxt      = rbin + PW'(pop);
   assign rgray_nxt     = PW'(bin2gray(32'(rbin_nxt)));
   assign wsync_bin_nxt = PW'(gray2bin(32'(wq1)));
   assign depth_nxt     = wsync_bin_nxt - rbin_nxt;

   always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
      if (!i_rd_rstn) begin
         rbin        <= '0;
         rgray       <= '0;
         wq1         <= '0;
         wq2         <= '0;
         o_rd_valid  <= '0;
         o_rd_empty  <= 1'b1;
         o_rd_aempty <= 1'b1;
         o_rd_pempty <= 1'b1;
         o_rd_depth  <= '0;
      end else begin
         rbin        <= rbin_nxt;
         rgray       <= rgray_nxt;
         wq1         <= wgray;
         wq2         <= wq1;
         o_rd_valid  <= serve;
         o_rd_empty  <= (depth_nxt == '0);
         o_rd_aempty <= (depth_nxt <= PW'(1));
         o_rd_pempty <= (depth_nxt <= PEMPTY);
         o_rd_depth  <= depth_nxt;
      end
   end

   // Unserved lanes keep their last delivered word.
   always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
      if (!i_rd_rstn) begin
         o_rd_data <= '0;
         o_rd_src  <= '0;
      end else begin
         for (int n = 0; n < N_READERS; n++)
            if (serve[n]) begin
               o_rd_data[n*WIDTH +: WIDTH] <= rd_entry[WIDTH-1:0];
               o_rd_src[n*SRC_W +: SRC_W]  <= rd_entry[EW-1 -: SRC_W];
            end
      end
   end

`ifdef MTON_FIFO_STATS_EN
   localparam logic [STAT_W-1:0] SAT = '1;

   always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
      if (!i_wr_rstn) begin
         o_wr_trial <= '0;
         o_wr_count <= '0;
         o_wr_fail  <= '0;
      end else begin
         if (|i_wr_en && o_wr_trial != SAT)              o_wr_trial <= o_wr_trial + 1'b1;
         if (push && o_wr_count != SAT)                  o_wr_count <= o_wr_count + 1'b1;
         if (|i_wr_en && o_wr_full && o_wr_fail != SAT)  o_wr_fail  <= o_wr_fail + 1'b1;
      end
   end

   always_ff @(posedge i_rd_clk or negedge i_rd_rstn) begin
      if (!i_rd_rstn) begin
         o_rd_trial <= '0;
         o_rd_count <= '0;
         o_rd_fail  <= '0;
      end else begin
         if (|i_rd_en && o_rd_trial != SAT)              o_rd_trial <= o_rd_trial + 1'b1;
         if (pop && o_rd_count != SAT)                   o_rd_count <= o_rd_count + 1'b1;
         if (|i_rd_en && o_rd_empty && o_rd_fail != SAT) o_rd_fail  <= o_rd_fail + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_mton_rr_async_fifo.sv
// tb_mton_rr_async_fifo
//   Directed bench for mton_rr_async_fifo (WIDTH=8, DEPTH=5, M=N=2).
//   u_dut uses round-robin arbitration, u_fix uses fixed priority.
//   Write clock period 4, read clock period 14.
module tb_mton_rr_async_fifo;

   logic wclk = 1'b0;
   logic rclk = 1'b0;
   logic wr_rstn, rd_rstn;

   always #2 wclk = ~wclk;
   always #7 rclk = ~rclk;

   // round-robin instance
   logic [1:0]  wr_en, wr_ed, rd_en, rd_valid, rd_src;
   logic [15:0] wr_data, rd_data;
   logic        wr_full, wr_afull, wr_pfull, rd_empty, rd_aempty, rd_pempty;
   logic [5:0]  wr_remain, rd_depth;

   // fixed-priority instance
   logic [1:0]  f_wr_en, f_wr_ed, f_rd_en, f_rd_valid, f_rd_src;
   logic [15:0] f_wr_data, f_rd_data;
   logic        f_wr_full, f_wr_afull, f_wr_pfull, f_rd_empty, f_rd_aempty, f_rd_pempty;
   logic [5:0]  f_wr_remain, f_rd_depth;

`ifdef MTON_FIFO_STATS_EN
   logic [31:0] wr_trial, wr_count, wr_fail, rd_trial, rd_count, rd_fail;
   logic [31:0] f_wr_trial, f_wr_count, f_wr_fail, f_rd_trial, f_rd_count, f_rd_fail;
`endif

   mton_rr_async_fifo #(.WIDTH(8), .DEPTH(5), .PFULL_TH(8), .PEMPTY_TH(8),
                        .M_WRITERS(2), .N_READERS(2), .ARB_MODE(0)) u_dut (
      .i_wr_clk(wclk), .i_wr_rstn(wr_rstn), .i_rd_clk(rclk), .i_rd_rstn(rd_rstn),
      .i_wr_en(wr_en), .i_wr_data(wr_data), .o_wr_ed(wr_ed),
      .o_wr_full(wr_full), .o_wr_afull(wr_afull), .o_wr_pfull(wr_pfull), .o_wr_remain(wr_remain),
      .i_rd_en(rd_en), .o_rd_data(rd_data), .o_rd_src(rd_src), .o_rd_valid(rd_valid),
      .o_rd_empty(rd_empty), .o_rd_aempty(rd_aempty), .o_rd_pempty(rd_pempty), .o_rd_depth(rd_depth)
`ifdef MTON_FIFO_STATS_EN
     ,.o_wr_trial(wr_trial), .o_wr_count(wr_count), .o_wr_fail(wr_fail),
      .o_rd_trial(rd_trial), .o_rd_count(rd_count), .o_rd_fail(rd_fail)
`endif
   );

   mton_rr_async_fifo #(.WIDTH(8), .DEPTH(5), .PFULL_TH(8), .PEMPTY_TH(8),
                        .M_WRITERS(2), .N_READERS(2), .ARB_MODE(1)) u_fix (
      .i_wr_clk(wclk), .i_wr_rstn(wr_rstn), .i_rd_clk(rclk), .i_rd_rstn(rd_rstn),
      .i_wr_en(f_wr_en), .i_wr_data(f_wr_data), .o_wr_ed(f_wr_ed),
      .o_wr_full(f_wr_full), .o_wr_afull(f_wr_afull), .o_wr_pfull(f_wr_pfull), .o_wr_remain(f_wr_remain),
      .i_rd_en(f_rd_en), .o_rd_data(f_rd_data), .o_rd_src(f_rd_src), .o_rd_valid(f_rd_valid),
      .o_rd_empty(f_rd_empty), .o_rd_aempty(f_rd_aempty), .o_rd_pempty(f_rd_pempty), .o_rd_depth(f_rd_depth)
`ifdef MTON_FIFO_STATS_EN
     ,.o_wr_trial(f_wr_trial), .o_wr_count(f_wr_count), .o_wr_fail(f_wr_fail),
      .o_rd_trial(f_rd_trial), .o_rd_count(f_rd_count), .o_rd_fail(f_rd_fail)
`endif
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   localparam int NRAND = 3000;

   logic [8:0] sb[$];          // {src, data} in write order
   logic [7:0] e;
   int         w_lane, w_tmo, r_lane, r_tmo;
   logic [7:0] w_d;
   logic [8:0] r_exp;

   initial begin
      wr_en = '0; wr_data = '0; rd_en = '0;
      f_wr_en = '0; f_wr_data = '0; f_rd_en = '0;
      wr_rstn = 1'b1; rd_rstn = 1'b1;
      #1;
      wr_rstn = 1'b0; rd_rstn = 1'b0;
      repeat (4) @(negedge rclk);

      // ---- reset state ----
      chk("rst_remain", wr_remain, 32);
      chk("rst_full",   wr_full,   0);
      chk("rst_afull",  wr_afull,  0);
      chk("rst_pfull",  wr_pfull,  0);
      chk("rst_empty",  rd_empty,  1);
      chk("rst_aempty", rd_aempty, 1);
      chk("rst_pempty", rd_pempty, 1);
      chk("rst_depth",  rd_depth,  0);
      chk("rst_valid",  rd_valid,  0);
      chk("rst_data",   rd_data,   0);
      chk("rst_src",    rd_src,    0);
      @(negedge wclk);
      wr_rstn = 1'b1; rd_rstn = 1'b1;
      repeat (3) @(negedge wclk);

      // ---- fill: both writers, grants alternate 0,1,0,... ----
      for (int i = 0; i < 32; i++) begin
         wr_en   = 2'b11;
         wr_data = {8'(i) | 8'h80, 8'(i)};
         #1;
         chk("fill_ed", wr_ed, (i % 2) ? 2'b10 : 2'b01);
         @(negedge wclk);
         chk("fill_remain", wr_remain, 31 - i);
         chk("fill_pfull",  wr_pfull,  (31 - i) <= 8);
         chk("fill_afull",  wr_afull,  (31 - i) <= 1);
         chk("fill_full",   wr_full,   i == 31);
      end
      repeat (3) begin
         #1;
         chk("full_no_ed", wr_ed, 0);
         @(negedge wclk);
         chk("full_remain", wr_remain, 0);
      end
      wr_en = '0;

      repeat (5) @(negedge rclk);
      chk("full_depth",  rd_depth,  32);
      chk("full_empty",  rd_empty,  0);
      chk("full_pempty", rd_pempty, 0);

      // ---- drain through reader 0 only ----
      rd_en = 2'b01;
      for (int i = 0; i < 32; i++) begin
         @(negedge rclk);
         e = (i % 2) ? (8'(i) | 8'h80) : 8'(i);
         chk("drain_valid",  rd_valid,     2'b01);
         chk("drain_data",   rd_data[7:0], e);
         chk("drain_src",    rd_src[0],    i % 2);
         chk("drain_depth",  rd_depth,     31 - i);
         chk("drain_aempty", rd_aempty,    (31 - i) <= 1);
         chk("drain_empty",  rd_empty,     i == 31);
         if (i == 31) rd_en = '0;
      end
      @(negedge rclk);
      chk("drain_idle_valid", rd_valid,     0);
      chk("drain_hold_data",  rd_data[7:0], 8'h9F);
      chk("drain_empty_end",  rd_empty,     1);
      repeat (5) @(negedge wclk);
      chk("drain_wr_remain", wr_remain, 32);
      chk("drain_wr_full",   wr_full,   0);

      // ---- fixed priority: lane 0 wins while requesting ----
      @(negedge wclk);
      for (int k = 0; k < 3; k++) begin
         f_wr_en   = 2'b11;
         f_wr_data = {8'hB0 + 8'(k), 8'hA0 + 8'(k)};
         #1;
         chk("fix_wr_ed0", f_wr_ed, 2'b01);
         @(negedge wclk);
      end
      f_wr_en   = 2'b10;
      f_wr_data = {8'hB3, 8'hA3};
      #1;
      chk("fix_wr_ed1", f_wr_ed, 2'b10);
      @(negedge wclk);
      f_wr_en = '0;
      repeat (5) @(negedge rclk);
      f_rd_en = 2'b11;
      @(negedge rclk);
      chk("fix_rd_v0a", f_rd_valid,     2'b01);
      chk("fix_rd_d0a", f_rd_data[7:0], 8'hA0);
      @(negedge rclk);
      chk("fix_rd_v0b", f_rd_valid,     2'b01);
      chk("fix_rd_d0b", f_rd_data[7:0], 8'hA1);
      f_rd_en = 2'b10;
      @(negedge rclk);
      chk("fix_rd_v1",   f_rd_valid,      2'b10);
      chk("fix_rd_d1",   f_rd_data[15:8], 8'hA2);
      chk("fix_rd_s1",   f_rd_src[1],     0);
      chk("fix_rd_hold", f_rd_data[7:0],  8'hA1);
      f_rd_en = '0;

      // ---- concurrent random traffic against a scoreboard ----
      fork
         begin
            for (int k = 0; k < NRAND; k++) begin
               @(negedge wclk);
               if ($urandom_range(0, 3) == 0) begin
                  wr_en = '0;
                  @(negedge wclk);
               end
               w_lane  = int'($urandom_range(0, 1));
               w_d     = 8'($urandom);
               wr_en   = '0;
               wr_en[w_lane] = 1'b1;
               wr_data = '0;
               wr_data[w_lane*8 +: 8] = w_d;
               w_tmo = 0;
               #1;
               while (!wr_ed[w_lane] && w_tmo < 1000) begin
                  @(negedge wclk);
                  #1;
                  w_tmo++;
               end
               chk("rand_wr_grant", wr_ed[w_lane], 1);
               if (wr_ed[w_lane]) sb.push_back({w_lane[0], w_d});
            end
            @(negedge wclk);
            wr_en = '0;
         end
         begin
            for (int k = 0; k < NRAND; k++) begin
               @(negedge rclk);
               if ($urandom_range(0, 3) == 0) begin
                  rd_en = '0;
                  @(negedge rclk);
               end
               r_lane = int'($urandom_range(0, 1));
               rd_en  = '0;
               rd_en[r_lane] = 1'b1;
               r_tmo = 0;
               @(negedge rclk);
               while (!rd_valid[r_lane] && r_tmo < 1000) begin
                  @(negedge rclk);
                  r_tmo++;
               end
               rd_en = '0;
               chk("rand_rd_valid", rd_valid[r_lane], 1);
               if (rd_valid[r_lane]) begin
                  chk("rand_sb_avail", sb.size() != 0, 1);
                  if (sb.size() != 0) begin
                     r_exp = sb.pop_front();
                     chk("rand_rd_data", rd_data[r_lane*8 +: 8], r_exp[7:0]);
                     chk("rand_rd_src",  rd_src[r_lane],         r_exp[8]);
                  end
               end
            end
         end
      join
      repeat (6) @(negedge rclk);
      chk("rand_end_empty", rd_empty,  1);
      chk("rand_end_depth", rd_depth,  0);
      chk("rand_sb_left",   sb.size(), 0);
      repeat (4) @(negedge wclk);
      chk("rand_end_remain", wr_remain, 32);

      // ---- flush with both resets while holding 10 entries ----
      @(negedge wclk);
      wr_en = 2'b01;
      for (int k = 0; k < 10; k++) begin
         wr_data[7:0] = 8'h50 + 8'(k);
         @(negedge wclk);
      end
      wr_en = '0;
      repeat (5) @(negedge rclk);
      chk("pre_rst_depth", rd_depth, 10);
      wr_rstn = 1'b0; rd_rstn = 1'b0;
      repeat (4) @(negedge rclk);
      wr_en = 2'b01;
      #1;
      chk("in_rst_ed",     wr_ed,     0);
      wr_en = '0;
      chk("in_rst_remain", wr_remain, 32);
      chk("in_rst_full",   wr_full,   0);
      chk("in_rst_empty",  rd_empty,  1);
      chk("in_rst_depth",  rd_depth,  0);
      chk("in_rst_valid",  rd_valid,  0);
      @(negedge wclk);
      wr_rstn = 1'b1; rd_rstn = 1'b1;
      repeat (2) @(negedge wclk);
      chk("post_rst_remain", wr_remain, 32);
      wr_en = 2'b10;
      wr_data[15:8] = 8'h5A;
      #1;
      chk("post_rst_ed", wr_ed, 2'b10);
      @(negedge wclk);
      wr_en = '0;
      repeat (5) @(negedge rclk);
      chk("post_rst_depth", rd_depth, 1);
      rd_en = 2'b10;
      @(negedge rclk);
      rd_en = '0;
      chk("post_rst_valid", rd_valid,      2'b10);
      chk("post_rst_data",  rd_data[15:8], 8'h5A);
      chk("post_rst_src",   rd_src[1],     1);

`ifdef MTON_FIFO_STATS_EN
      // ---- statistics: 40 attempts into an empty FIFO ----
      @(negedge wclk);
      wr_rstn = 1'b0; rd_rstn = 1'b0;
      repeat (4) @(negedge rclk);
      @(negedge wclk);
      wr_rstn = 1'b1; rd_rstn = 1'b1;
      @(negedge wclk);
      wr_en = 2'b01;
      repeat (40) @(negedge wclk);
      wr_en = '0;
      chk("stat_trial", wr_trial, 40);
      chk("stat_count", wr_count, 32);
      chk("stat_fail",  wr_fail,  8);
      chk("stat_full",  wr_full,  1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
